// File: rtl/lms_adaptive_fir.sv
// Time-multiplexed LMS adaptive FIR sharing one multiplier between filtering and weight update.
// Optional LMS_ADAPT_GATE_EN adds an adapt_en input that can freeze the weights per sample.
module lms_adaptive_fir #(
  parameter int TAPS     = 8,
  parameter int MU_SHIFT = 4,
  parameter int DW       = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] e_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
`ifdef LMS_ADAPT_GATE_EN
  ,
  input  logic          adapt_en
`endif
);

  // state  | meaning
  // IDLE   | waiting for in_valid
  // FILTER | one tap per clock: acc += w[k]*x_dl[k]
  // ERROR  | scale/saturate y, form e, register outputs
  // UPDATE | one tap per clock: w[k] += (e*x_dl[k]) >>> (DW-1+MU_SHIFT)

  localparam int CW = $clog2(TAPS);
  localparam int AW = 2*DW + CW;
  localparam int SH = DW - 1 + MU_SHIFT;
  localparam logic [CW-1:0] LAST_K = CW'(TAPS - 1);
  localparam logic [DW-1:0] MAX_V  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILTER, ERROR, UPDATE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_tap;
  logic [DW-1:0] w    [TAPS];
  logic [DW-1:0] x_dl [TAPS];
  logic [DW-1:0] d_reg;
  logic [AW-1:0] acc;
  logic [DW-1:0] op_a, op_b;
  logic [2*DW-1:0] prod;
  logic [AW-1:0] acc_sh;
  logic [DW-1:0] y_sat, e_sat, w_upd;
  logic [DW:0]   e_full, delta, w_sum;
  logic          adapt_q;

  function automatic logic [DW-1:0] sat_acc(input logic [AW-1:0] v);
    if (&v[AW-1:DW-1] || ~|v[AW-1:DW-1]) return v[DW-1:0];
    return v[AW-1] ? MIN_V : MAX_V;
  endfunction

  function automatic logic [DW-1:0] sat_one(input logic [DW:0] v);
    if (v[DW] == v[DW-1]) return v[DW-1:0];
    return v[DW] ? MIN_V : MAX_V;
  endfunction

  assign last_tap = (cnt == '0);

  // Operands are sign-extended to full width so the unsigned product is the exact signed product.
  assign prod   = {{DW{op_a[DW-1]}}, op_a} * {{DW{op_b[DW-1]}}, op_b};
  assign acc_sh = AW'($signed(acc) >>> (DW-1));
  assign y_sat  = sat_acc(acc_sh);
  assign e_full = {d_reg[DW-1], d_reg} - {y_sat[DW-1], y_sat};
  assign e_sat  = sat_one(e_full);
  assign delta  = (DW+1)'($signed(prod) >>> SH);
  assign w_sum  = {w[cnt][DW-1], w[cnt]} + delta;
  assign w_upd  = sat_one(w_sum);

`ifdef LMS_ADAPT_GATE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          adapt_q <= 1'b0;
    else if (state == IDLE && in_valid)  adapt_q <= adapt_en;
  end
`else
  assign adapt_q = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = FILTER;
      FILTER:  if (last_tap) state_nxt = ERROR;
      ERROR:   state_nxt = adapt_q ? UPDATE : IDLE;
      UPDATE:  if (last_tap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    op_a = (state == UPDATE) ? e_out : w[cnt];
    op_b = x_dl[cnt];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= LAST_K;
      acc       <= '0;
      d_reg     <= '0;
      y_out     <= '0;
      e_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        w[k]    <= '0;
        x_dl[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          d_reg   <= d_in;
          x_dl[0] <= x_in;
          for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
          acc     <= '0;
          cnt     <= LAST_K;
        end
        FILTER: begin
          acc <= acc + {{CW{prod[2*DW-1]}}, prod};
          cnt <= last_tap ? LAST_K : cnt - 1'b1;
        end
        ERROR: begin
          y_out     <= y_sat;
          e_out     <= e_sat;
          out_valid <= 1'b1;
          cnt       <= LAST_K;
        end
        UPDATE: begin
          w[cnt] <= w_upd;
          cnt    <= last_tap ? LAST_K : cnt - 1'b1;
        end
        default: cnt <= LAST_K;
      endcase
    end
  end

endmodule
